fp_align: RTL

FP_ALIGN -- requirements
Module: fp_align

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_align_if.sv | 20 ++
 rtl/fp_rshift_sticky.sv | 14 +
 rtl/fp_align.sv | 102 ++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths and the unpacked-operand type for the FP alignment path.
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int MANT_W = 23;
    localparam int GRS_W = 3;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
    localparam int SIG_W = MANT_W + 1;
    localparam int ALN_W = SIG_W + GRS_W;
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] e;
        logic [SIG_W-1:0] m;
    } fp_unpacked_t;
    // Denormals get exponent 1 with hidden bit 0 so they align like normals.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        u.e = (x[30:23] == '0) ? 8'd1 : x[30:23];
        u.m = {x[30:23] != '0, x[22:0]};
        return u;
    endfunction
endpackage

// File: rtl/fp_align_if.sv
// fp_align_if: operand input and aligned-operand output handshakes of fp_align.
interface fp_align_if;
    import fp_pkg::*;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] exp_large;
    logic [SIG_W-1:0] mant_large;
    logic [ALN_W-1:0] mant_small;
    logic             sign_large;
    logic             eff_sub;
    logic             special;
    modport slave (input a, b, in_valid, out_ready,
                   output in_ready, out_valid, exp_large, mant_large, mant_small, sign_large, eff_sub, special);
    modport master (output a, b, in_valid, out_ready,
                    input in_ready, out_valid, exp_large, mant_large, mant_small, sign_large, eff_sub, special);
endinterface

// File: rtl/fp_rshift_sticky.sv
// fp_rshift_sticky: right shift with every shifted-out bit ORed into the LSB.
module fp_rshift_sticky
    import fp_pkg::*;
(
    input  logic [ALN_W-1:0] i_val,
    input  logic [4:0]       i_amt,
    output logic [ALN_W-1:0] o_val
);
    logic [ALN_W-1:0] w_shift;
    logic [ALN_W-1:0] w_lost_mask;
    assign w_shift = i_val >> i_amt;
    assign w_lost_mask = ~({ALN_W{1'b1}} << i_amt);
    assign o_val = {w_shift[ALN_W-1:1], w_shift[0] | (|(i_val & w_lost_mask))};
endmodule

// File: rtl/fp_align.sv
// fp_align: two-stage valid/ready pipeline that orders two floats by magnitude
// and aligns the smaller mantissa to the larger exponent with guard/round/sticky.
module fp_align
    import fp_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    fp_align_if.slave bus
);
    fp_unpacked_t     w_a, w_b, w_l, w_s;
    logic             w_a_large;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [4:0]       w_amt;
    logic [ALN_W-1:0] w_aligned;
    logic             r_s1_valid;
    logic [EXP_W-1:0] r_s1_exp;
    logic [SIG_W-1:0] r_s1_ml;
    logic [SIG_W-1:0] r_s1_ms;
    logic [EXP_W-1:0] r_s1_diff;
    logic             r_s1_sign;
    logic             r_s1_sub;
    logic             r_s1_special;
    logic             r_s2_valid;
    logic [EXP_W-1:0] r_s2_exp;
    logic [SIG_W-1:0] r_s2_ml;
    logic [ALN_W-1:0] r_s2_ms;
    logic             r_s2_sign;
    logic             r_s2_sub;
    logic             r_s2_special;

    assign w_a = fp_unpack(bus.a);
    assign w_b = fp_unpack(bus.b);
    assign w_a_large = (w_a.e > w_b.e) | ((w_a.e == w_b.e) & (w_a.m >= w_b.m));
    assign w_l = w_a_large ? w_a : w_b;
    assign w_s = w_a_large ? w_b : w_a;
    assign w_s2_adv = !r_s2_valid | bus.out_ready;
    assign w_s1_adv = !r_s1_valid | w_s2_adv;
    assign bus.in_ready = w_s1_adv;
    // Saturating at 31 is enough: any shift of 27 or more empties the field.
    assign w_amt = (r_s1_diff > 8'd31) ? 5'd31 : r_s1_diff[4:0];

    fp_rshift_sticky u_shift (
        .i_val ({r_s1_ms, {GRS_W{1'b0}}}),
        .i_amt (w_amt),
        .o_val (w_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_ml      <= '0;
            r_s1_ms      <= '0;
            r_s1_diff    <= '0;
            r_s1_sign    <= 1'b0;
            r_s1_sub     <= 1'b0;
            r_s1_special <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_exp     <= w_l.e;
                r_s1_ml      <= w_l.m;
                r_s1_ms      <= w_s.m;
                r_s1_diff    <= w_l.e - w_s.e;
                r_s1_sign    <= w_l.sign;
                r_s1_sub     <= w_a.sign ^ w_b.sign;
                r_s1_special <= (bus.a[30:23] == EXP_SPECIAL) | (bus.b[30:23] == EXP_SPECIAL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_exp     <= '0;
            r_s2_ml      <= '0;
            r_s2_ms      <= '0;
            r_s2_sign    <= 1'b0;
            r_s2_sub     <= 1'b0;
            r_s2_special <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_exp     <= r_s1_exp;
                r_s2_ml      <= r_s1_ml;
                r_s2_ms      <= w_aligned;
                r_s2_sign    <= r_s1_sign;
                r_s2_sub     <= r_s1_sub;
                r_s2_special <= r_s1_special;
            end
        end
    end

    assign bus.out_valid  = r_s2_valid;
    assign bus.exp_large  = r_s2_exp;
    assign bus.mant_large = r_s2_ml;
    assign bus.mant_small = r_s2_ms;
    assign bus.sign_large = r_s2_sign;
    assign bus.eff_sub    = r_s2_sub;
    assign bus.special    = r_s2_special;
endmodule
